// File: rtl/alu_muldiv_sequencer_if.sv
// Handshake bundle between the EX stage and the mul/div sequencer.
// EX drives requests and operands; the sequencer returns HI/LO and status.
interface alu_muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             mf_req;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output start, op, rs_val, rt_val, mf_req, mthi, mtlo, wdata,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  start, op, rs_val, rt_val, mf_req, mthi, mtlo, wdata,
        output hi, lo, busy, done, stall
    );
endinterface

// File: rtl/alu_muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// One bit per cycle: shift-add multiply, restoring divide on magnitudes,
// with sign correction applied in a final FIX cycle.
module alu_muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_muldiv_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH:0]   acc;
    logic [2*WIDTH:0]   acc_step;
    logic [WIDTH-1:0]   opnd;
    logic [1:0]         op_q;
    logic               neg_res;
    logic               neg_dvd;
    logic               dz;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    // Capture-side helpers
    logic               signed_op;
    logic               rs_neg;
    logic               rt_neg;
    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   rt_mag;
    logic               cap_mul;

    // Iteration helpers
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH:0]   div_sh;
    logic [WIDTH:0]     div_trial;

    // Sign-corrected results
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    logic               busy;

    assign signed_op = ~bus.op[0];
    assign rs_neg    = signed_op & bus.rs_val[WIDTH-1];
    assign rt_neg    = signed_op & bus.rt_val[WIDTH-1];
    assign rs_mag    = rs_neg ? -bus.rs_val : bus.rs_val;
    assign rt_mag    = rt_neg ? -bus.rt_val : bus.rt_val;
    assign cap_mul   = ~bus.op[1];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: capture, WIDTH iterations, then one fix-up cycle
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.start) state_nxt = S_RUN;
            S_RUN:  if (cnt == CNT_W'(WIDTH - 1)) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // One multiply or divide iteration on the accumulator
    always_comb begin
        acc_step  = acc;
        mul_sum   = '0;
        div_sh    = '0;
        div_trial = '0;
        if (!op_q[1]) begin
            // Multiplier sits in the low half; add multiplicand on LSB, shift right
            mul_sum  = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, opnd} : '0);
            acc_step = {1'b0, mul_sum, acc[WIDTH-1:1]};
        end else begin
            // Remainder in the upper half, dividend/quotient in the low half
            div_sh    = {acc[2*WIDTH-1:0], 1'b0};
            div_trial = div_sh[2*WIDTH:WIDTH] - {1'b0, opnd};
            if (!div_trial[WIDTH]) begin
                acc_step = {div_trial, div_sh[WIDTH-1:1], 1'b1};
            end else begin
                acc_step = div_sh;
            end
        end
    end

    // Sign correction of the finished magnitudes
    always_comb begin
        prod     = acc[2*WIDTH-1:0];
        prod_fix = neg_res ? -prod : prod;
        quot_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_dvd ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (!op_q[1]) begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end else begin
            // With a zero divisor the remainder is the dividend magnitude,
            // so re-signing it restores the original rs_val exactly
            fix_hi = rem_fix;
            fix_lo = dz ? '1 : quot_fix;
        end
    end

    // Operand capture, iteration state, HI/LO and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            op_q    <= '0;
            neg_res <= 1'b0;
            neg_dvd <= 1'b0;
            dz      <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state == S_FIX);
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q    <= bus.op;
                        neg_res <= rs_neg ^ rt_neg;
                        neg_dvd <= rs_neg;
                        dz      <= bus.op[1] & (bus.rt_val == '0);
                        opnd    <= cap_mul ? rs_mag : rt_mag;
                        acc     <= {{(WIDTH+1){1'b0}}, (cap_mul ? rt_mag : rs_mag)};
                        cnt     <= '0;
                    end else begin
                        if (bus.mthi) hi_q <= bus.wdata;
                        if (bus.mtlo) lo_q <= bus.wdata;
                    end
                end
                S_RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + CNT_W'(1);
                end
                S_FIX: begin
                    hi_q <= fix_hi;
                    lo_q <= fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign bus.busy  = busy;
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.stall = busy & (bus.start | bus.mf_req | bus.mthi | bus.mtlo);

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Scoreboard bench for alu_muldiv_sequencer: directed vectors push expected
// HI/LO pairs; a monitor pops and compares on each done pulse.
module tb_alu_muldiv_sequencer;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        string        name;
    } exp_t;

    logic clk;
    logic rst_n;
    int   vectors;
    int   errs;
    exp_t sb[$];

    alu_muldiv_sequencer_if #(.WIDTH(W)) bus ();

    alu_muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                errs++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_hi"}, bus.hi, e.hi);
                chk({e.name, "_lo"}, bus.lo, e.lo);
            end
        end
    end

    task automatic drive_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] eh, input logic [W-1:0] el, input string nm);
        exp_t e;
        bus.start  = 1'b1;
        bus.op     = op;
        bus.rs_val = a;
        bus.rt_val = b;
        e.hi = eh;
        e.lo = el;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Wait (bounded) for the next done pulse; start is dropped on the first cycle
    task automatic wait_done(input string nm, output int nbusy);
        bit seen;
        seen  = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 0) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy === 1'b1) nbusy++;
        end
        chk({nm, "_done_seen"}, W'(seen), W'(1));
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eh, input logic [W-1:0] el, input string nm);
        int nb;
        @(negedge clk);
        drive_op(op, a, b, eh, el, nm);
        wait_done(nm, nb);
        chk({nm, "_busy_cycles"}, W'(nb), W'(33));
        chk({nm, "_stall_idle"}, W'(bus.stall), W'(0));
        @(negedge clk);
        chk({nm, "_done_width"}, W'(bus.done), W'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  nb;
        int  nst;
        bit  ok;
        bit  seen;

        vectors    = 0;
        errs       = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.op     = 2'd0;
        bus.rs_val = '0;
        bus.rt_val = '0;
        bus.mf_req = 1'b0;
        bus.mthi   = 1'b0;
        bus.mtlo   = 1'b0;
        bus.wdata  = '0;

        repeat (3) @(negedge clk);
        chk("rst_hi", bus.hi, '0);
        chk("rst_lo", bus.lo, '0);
        chk("rst_busy", W'(bus.busy), W'(0));
        chk("rst_done", W'(bus.done), W'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // MULT 7 * -3 = -21
        run_op(2'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg");

        // MULTU, with a DIV held under stall and accepted at the busy-fall edge
        @(negedge clk);
        drive_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
        @(negedge clk);
        drive_op(2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7_2");
        chk("b2b_stall", W'(bus.stall), W'(1));
        ok   = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy === 1'b1 && bus.stall !== 1'b1) ok = 1'b0;
        end
        chk("b2b_first_done", W'(seen), W'(1));
        chk("b2b_stall_held", W'(ok), W'(1));
        chk("b2b_stall_fall", W'(bus.stall), W'(0));
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_accepted", W'(bus.busy), W'(1));
        wait_done("b2b_second", nb);
        chk("b2b_second_busy", W'(nb), W'(32));

        // Divide corner cases
        run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_minneg");
        run_op(2'd3, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, "divu_zero");
        run_op(2'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, "div_neg_zero");
        run_op(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100_7");

        // MFHI/MFLO request from busy cycle 5 stalls until idle
        @(negedge clk);
        drive_op(2'd0, 32'h00010000, 32'h00030000, 32'h00000003, 32'h00000000, "mult_mf");
        nst  = 0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 0) bus.start = 1'b0;
            if (i == 4) bus.mf_req = 1'b1;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus.stall === 1'b1) nst++;
        end
        chk("mf_done_seen", W'(seen), W'(1));
        chk("mf_stall_cycles", W'(nst), W'(29));
        chk("mf_stall_idle", W'(bus.stall), W'(0));
        bus.mf_req = 1'b0;

        // MTLO, then MTHI+MTLO together
        @(negedge clk);
        bus.mtlo  = 1'b1;
        bus.wdata = 32'hA5A5A5A5;
        @(negedge clk);
        bus.mtlo = 1'b0;
        chk("mtlo_lo", bus.lo, 32'hA5A5A5A5);
        chk("mtlo_hi", bus.hi, 32'h00000003);
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h5A5A5A5A;
        @(negedge clk);
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        chk("mtboth_hi", bus.hi, 32'h5A5A5A5A);
        chk("mtboth_lo", bus.lo, 32'h5A5A5A5A);

        // Start together with MTLO: start wins, MT write dropped
        drive_op(2'd1, 32'd2, 32'd3, 32'd0, 32'd6, "multu_vs_mt");
        bus.mtlo  = 1'b1;
        bus.wdata = 32'hDEADBEEF;
        @(negedge clk);
        bus.start = 1'b0;
        bus.mtlo  = 1'b0;
        chk("mt_dropped_lo", bus.lo, 32'h5A5A5A5A);
        chk("mt_dropped_busy", W'(bus.busy), W'(1));
        wait_done("multu_vs_mt", nb);

        // Asynchronous reset in the middle of a DIV
        @(negedge clk);
        drive_op(2'd2, 32'd100, 32'd7, 32'd2, 32'd14, "div_abort");
        bus.mf_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) bus.start = 1'b0;
        end
        chk("abort_pre_stall", W'(bus.stall), W'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", W'(bus.busy), W'(0));
        chk("abort_done", W'(bus.done), W'(0));
        chk("abort_stall", W'(bus.stall), W'(0));
        chk("abort_hi", bus.hi, '0);
        chk("abort_lo", bus.lo, '0);
        sb.delete();
        bus.mf_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        chk("abort_no_done", W'(seen), W'(0));
        chk("abort_idle", W'(bus.busy), W'(0));

        chk("sb_empty", W'(sb.size()), W'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
